// File: rtl/lfsr_rand_pkg.sv
// rtl/lfsr_rand_pkg.sv - shared state encoding and default LFSR constants for the random scheduler
package lfsr_rand_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    SHIFT   = 2'd2,
    DELIVER = 2'd3
  } state_e;

  localparam logic [15:0] TAPS_DEFAULT     = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT_VAL = 16'h0001;

endpackage

// File: rtl/lfsr_rand_scheduler_if.sv
// rtl/lfsr_rand_scheduler_if.sv - requester/seed/word bundle between consumers and the random scheduler
interface lfsr_rand_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int LFSR_W  = 16,
  parameter int OUT_W   = 8
);

  logic [NUM_REQ-1:0] req_in;
  logic               seed_load_in;
  logic [LFSR_W-1:0]  seed_data_in;
  logic               entropy_in;
  logic [NUM_REQ-1:0] ack_out;
  logic [OUT_W-1:0]   rand_out;
  logic               busy_out;

  modport master (
    output req_in, seed_load_in, seed_data_in, entropy_in,
    input  ack_out, rand_out, busy_out
  );

  modport slave (
    input  req_in, seed_load_in, seed_data_in, entropy_in,
    output ack_out, rand_out, busy_out
  );

endinterface

// File: rtl/lfsr_galois_core.sv
// rtl/lfsr_galois_core.sv - Galois LFSR with seed load, single-step advance and zero-state guard
// RAND_ENTROPY_MIX_EN folds entropy_i into the feedback bit of every step.
module lfsr_galois_core
  import lfsr_rand_pkg::*;
#(
  parameter int            W    = 16,
  parameter logic [W-1:0]  TAPS = W'(TAPS_DEFAULT),
  parameter logic [W-1:0]  SEED = W'(SEED_DEFAULT_VAL)
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         step_i,
  input  logic         entropy_i,
  output logic         out_bit_o
);

  logic [W-1:0] lfsr_q, lfsr_d, stepped;
  logic         fb;

`ifdef RAND_ENTROPY_MIX_EN
  assign fb = lfsr_q[0] ^ entropy_i;
`else
  logic unused_entropy;
  assign unused_entropy = entropy_i;
  assign fb = lfsr_q[0];
`endif

  always_comb begin
    stepped = (lfsr_q >> 1) ^ (fb ? TAPS : '0);
    lfsr_d  = lfsr_q;
    if (load_i) begin
      lfsr_d = load_data_i;
    end else if (step_i) begin
      lfsr_d = stepped;
    end
    // All-zero is a lock-up state; both a zero seed and a zero step land on 1.
    if (lfsr_d == '0) begin
      lfsr_d = W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out_bit_o = lfsr_q[0];

endmodule

// File: rtl/lfsr_rand_scheduler.sv
// rtl/lfsr_rand_scheduler.sv - round-robin sharing of one LFSR, one OUT_W-bit word per grant
// RAND_ENTROPY_MIX_EN (in lfsr_galois_core) mixes entropy_in into each LFSR step.
module lfsr_rand_scheduler
  import lfsr_rand_pkg::*;
#(
  parameter int                 NUM_REQ      = 4,
  parameter int                 LFSR_W       = 16,
  parameter int                 OUT_W        = 8,
  parameter logic [LFSR_W-1:0]  TAPS         = LFSR_W'(TAPS_DEFAULT),
  parameter logic [LFSR_W-1:0]  SEED_DEFAULT = LFSR_W'(SEED_DEFAULT_VAL)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  lfsr_rand_scheduler_if.slave ifc
);

  localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d, win_q, win_d, cand, idx;
  logic               found;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   word_q, word_d, word_shift;
  logic [OUT_W-1:0]   rand_q, rand_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               lfsr_step, lfsr_bit;

  lfsr_galois_core #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED_DEFAULT)
  ) u_core (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .load_i      (ifc.seed_load_in),
    .load_data_i (ifc.seed_data_in),
    .step_i      (lfsr_step),
    .entropy_i   (ifc.entropy_in),
    .out_bit_o   (lfsr_bit)
  );

  // First requesting index at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    cand  = rr_q;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(rr_q) + i) % NUM_REQ);
      if (!found && ifc.req_in[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  assign word_shift = (word_q << 1) | OUT_W'(lfsr_bit);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    ack_d     = '0;
    rand_d    = '0;
    lfsr_step = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|ifc.req_in) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          win_d   = cand;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        lfsr_step = 1'b1;
        word_d    = word_shift;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DELIVER;
          ack_d   = NUM_REQ'(1) << win_q;
          rand_d  = word_shift;
        end
      end
      DELIVER: begin
        rr_d    = (win_q == PTR_LAST) ? '0 : win_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reseed abandons any grant still in flight; an ack already registered stands.
    if (ifc.seed_load_in) begin
      state_d   = IDLE;
      ack_d     = '0;
      rand_d    = '0;
      lfsr_step = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      ack_q   <= '0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ack_q   <= ack_d;
      rand_q  <= rand_d;
    end
  end

  assign ifc.ack_out  = ack_q;
  assign ifc.rand_out = rand_q;
  assign ifc.busy_out = (state_q != IDLE);

endmodule

// File: doc/lfsr_rand_scheduler.md
# lfsr_rand_scheduler

Shares one Galois LFSR random source among NUM_REQ requesters. It arbitrates round-robin, steps the LFSR OUT_W times per grant, and returns one OUT_W-bit word per handshake. It also accepts runtime reseeding from external entropy such as ADC noise or a key-press duration count, so sequences are not fixed after reset. It sits between entropy sources and consumer blocks such as games, dithering and backoff timers.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- LFSR_W, 16, LFSR width
- OUT_W, 8, bits per delivered word (1..LFSR_W)
- TAPS, 16'hB400, Galois feedback mask XORed in when the shifted-out bit is 1
- SEED_DEFAULT, 16'h0001, LFSR value after reset (must be non-zero)
- clk_in  in  1  clock
- rst_n_in  in  1  reset, asynchronous, active-low
- req_in  in  NUM_REQ  level request per requester
- seed_load_in  in  1  one-cycle pulse: load seed_data_in
- seed_data_in  in  LFSR_W  new seed
- entropy_in  in  1  extra entropy bit (used only with RAND_ENTROPY_MIX_EN)
- ack_out  out  NUM_REQ  one-hot, one-cycle pulse: word delivered to that requester
- rand_out  out  OUT_W  random word; valid only while ack_out is non-zero
- busy_out  out  1  high in ARB/SHIFT/DELIVER

## Operation
- Reset values: state IDLE, lfsr=SEED_DEFAULT, rr pointer=0, bit counter=0, word=0, ack_out=0, rand_out=0, busy_out=0.
- States and transitions:
  - IDLE -> ARB when any req_in bit is high.
  - ARB (1 cycle): latch the winner. The winner is the first set req_in bit at or above the rr pointer, wrapping around; it is always a requester that is high in ARB. If no req_in bit is high in ARB, return to IDLE with no grant.
  - SHIFT (OUT_W cycles): each cycle word <= {word[OUT_W-2:0], lfsr[0]} and lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
  - DELIVER (1 cycle): ack_out[winner]=1, rand_out=word. rr pointer <= (winner+1) mod NUM_REQ.
  - DELIVER -> IDLE always. This gives the served requester one cycle to drop req_in.
- If a requester drops req_in during SHIFT, its word is still delivered and ack is still pulsed.
- Seed load has priority over the state machine in every state:
  - lfsr <= (seed_data_in==0) ? 1 : seed_data_in.
  - State returns to IDLE; an in-progress grant is cancelled with no ack.
  - The rr pointer is unchanged.
  - A seed load during DELIVER does not suppress that cycle's ack.
- The LFSR never holds 0. Any computed zero next state is forced to 1.

## Timing
- req_in high in IDLE at cycle t: ARB at t+1, SHIFT at t+2..t+1+OUT_W, ack at t+2+OUT_W. Latency is OUT_W+2 cycles.
- Back-to-back service: next ARB no earlier than 2 cycles after DELIVER. Throughput is one word per OUT_W+3 cycles.
- The LFSR steps only in SHIFT and is frozen otherwise.
- ack_out and rand_out are registered; rand_out returns to 0 after DELIVER.

## Configuration
- RAND_ENTROPY_MIX_EN defined: on each SHIFT step the feedback bit is lfsr[0]^entropy_in (entropy_in is sampled that cycle), and the zero-state guard still applies.
- RAND_ENTROPY_MIX_EN undefined: entropy_in is ignored and the sequence depends only on seeds. With entropy_in tied to 0, both builds produce identical output.

## Structure
- Package lfsr_rand_pkg: state enum (IDLE, ARB, SHIFT, DELIVER), default TAPS and SEED_DEFAULT constants.
- Sub-module lfsr_galois_core: LFSR register with load, step, zero guard and optional entropy mix. The top holds the FSM, round-robin arbiter and word assembly.

## Test plan
- Reset, then req_in=4'b0001 with defaults: ack_out=4'b0001 after 10 cycles with rand_out=8'h80. Second request: rand_out=8'h16.
- req_in=4'b1111 held: acks in order 0,1,2,3,0, each DELIVER separated by 11 cycles.
- seed_load_in with seed_data_in=0: LFSR=1, and the next word is 8'h80.
- seed_load_in in the 3rd SHIFT cycle: no ack for that grant; the same requester is served afterwards, with the word computed from the new seed.
- Assert rst_n_in mid-SHIFT: all outputs are 0 immediately, and the next word is 8'h80.
- Build with RAND_ENTROPY_MIX_EN, entropy_in=0: sequence 8'h80, 8'h16. With entropy_in=1: sequence differs, and the LFSR is never 0 over 10k words.
